// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction-fetch slice.
//   XLEN             datapath width
//   NOP_INSTR        instruction word shown to decode while nothing valid is held
//   DEFAULT_RESET_PC default first fetch address after reset
//   fetch_state_e    fetch FSM states (RUN issues requests, HALT does not)
//   fetch_entry_t    one fetch-queue entry: instruction address plus word
package riscv_pkg;

    localparam int              XLEN             = 32;
    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic {
        FETCH_RUN  = 1'b0,
        FETCH_HALT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry fetch queue holding {pc, instr} pairs between memory and decode.
//   clk, rst_n          clock, asynchronous active-low reset
//   i_push, i_push_pc,
//   i_push_instr        write one entry at the tail
//   i_pop               remove the head entry (ignored when empty)
//   i_flush             discard everything; wins over push and pop
//   o_head_pc,
//   o_head_instr        head entry, meaningful while !o_empty
//   o_full, o_empty     occupancy flags
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_push,
    input  logic [XLEN-1:0] i_push_pc,
    input  logic [XLEN-1:0] i_push_instr,
    input  logic            i_pop,
    input  logic            i_flush,
    output logic [XLEN-1:0] o_head_pc,
    output logic [XLEN-1:0] o_head_instr,
    output logic            o_full,
    output logic            o_empty
);

    fetch_entry_t r_mem [2];
    logic         r_rd_ptr;
    logic         r_wr_ptr;
    logic [1:0]   r_count;
    logic         w_push;
    logic         w_pop;

    assign o_full       = (r_count == 2'd2);
    assign o_empty      = (r_count == 2'd0);
    assign w_pop        = i_pop && !o_empty;
    // A push into a full queue is only legal when the head leaves this cycle.
    assign w_push       = i_push && (!o_full || w_pop);
    assign o_head_pc    = r_mem[r_rd_ptr].pc;
    assign o_head_instr = r_mem[r_rd_ptr].instr;

    // NOTE: storage is normally left unreset; it is reset here only because
    // the head entry is visible on the outputs and must read as a NOP at
    // RESET_PC while rst_n is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                r_mem[i] <= '{pc: RESET_PC, instr: NOP_INSTR};
            end
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (i_flush) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= '{pc: i_push_pc, instr: i_push_instr};
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues word-aligned requests to instruction
// memory, pairs in-order responses with their addresses, and offers them to
// decode through a two-entry queue. Handles redirects (flush plus discard of
// stale responses) and a halt/resume pause.
//   clk, rst_n                  clock, asynchronous active-low reset
//   imem_req, imem_addr         request to memory (held until imem_ready)
//   imem_ready                  memory accepts the request this cycle
//   imem_rvalid, imem_rdata     in-order response
//   redirect_valid, redirect_pc taken branch/jump target from execute
//   halt, resume                stop / restart issuing requests
//   if_valid, if_ready          handshake to decode
//   if_instr, if_pc             instruction word and its address
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int              FQ_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            halt,
    input  logic            resume,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc
);

    localparam logic [2:0] DEPTH = 3'(FQ_DEPTH);

    fetch_state_e    r_state;
    fetch_state_e    w_state_next;
    logic [XLEN-1:0] r_pc;
    logic [1:0]      r_outstanding;
    logic [1:0]      r_discard;
    logic            r_req_hold;

    logic            w_accept;
    logic            w_rsp;
    logic            w_drop;
    logic            w_push;
    logic            w_pop;
    logic            w_full;
    logic            w_empty;
    logic [1:0]      w_occupancy;
    logic [2:0]      w_used;
    logic [1:0]      w_outstanding_next;
    logic [XLEN-1:0] w_rsp_pc;
    logic            w_unused_lsb;

    assign w_unused_lsb = ^redirect_pc[1:0];

    assign w_occupancy = w_full ? 2'd2 : (w_empty ? 2'd0 : 2'd1);
    assign w_pop       = if_valid && if_ready;
    // Slots already promised: in-flight requests plus queued entries, less
    // the entry decode takes this cycle (a new response lands a cycle later).
    assign w_used      = {1'b0, r_outstanding} + {1'b0, w_occupancy} - {2'b00, w_pop};

    // r_req_hold keeps an unaccepted request up even if halt arrives or decode
    // stalls meanwhile; rst_n gating keeps the request low during reset while
    // still letting the first request go out in the cycle reset releases.
    assign imem_req  = rst_n && (r_req_hold || (r_state == FETCH_RUN && w_used < DEPTH));
    assign imem_addr = r_pc;
    assign w_accept  = imem_req && imem_ready;

    assign w_rsp  = imem_rvalid && (r_outstanding != 2'd0);
    assign w_drop = w_rsp && (r_discard != 2'd0);
    assign w_push = w_rsp && !w_drop && !redirect_valid;

    // Once every stale response has drained, the live requests are the
    // consecutive words just below r_pc, so the oldest one needs no storage.
    assign w_rsp_pc = r_pc - {{(XLEN-4){1'b0}}, r_outstanding, 2'b00};

    assign w_outstanding_next = r_outstanding + {1'b0, w_accept} - {1'b0, w_rsp};

    // NOTE: every variable written in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        if (redirect_valid) begin
            w_state_next = FETCH_RUN;
        end else begin
            case (r_state)
                FETCH_RUN:  if (halt)            w_state_next = FETCH_HALT;
                FETCH_HALT: if (resume && !halt) w_state_next = FETCH_RUN;
                default:                         w_state_next = FETCH_RUN;
            endcase
        end
    end

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= FETCH_RUN;
            r_pc          <= RESET_PC;
            r_outstanding <= 2'd0;
            r_discard     <= 2'd0;
            r_req_hold    <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_outstanding <= w_outstanding_next;
            r_req_hold    <= imem_req && !imem_ready && !redirect_valid;
            if (redirect_valid) begin
                r_pc      <= {redirect_pc[XLEN-1:2], 2'b00};
                // Everything still in flight after this edge, including an
                // acceptance made in this very cycle, belongs to the old path.
                r_discard <= w_outstanding_next;
            end else begin
                if (w_accept) begin
                    r_pc <= r_pc + XLEN'(4);
                end
                if (w_drop) begin
                    r_discard <= r_discard - 2'd1;
                end
            end
        end
    end

    fetch_fifo #(
        .RESET_PC (RESET_PC)
    ) u_fetch_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_push       (w_push),
        .i_push_pc    (w_rsp_pc),
        .i_push_instr (imem_rdata),
        .i_pop        (w_pop),
        .i_flush      (redirect_valid),
        .o_head_pc    (if_pc),
        .o_head_instr (if_instr),
        .o_full       (w_full),
        .o_empty      (w_empty)
    );

    assign if_valid = !w_empty;

endmodule
